conv_encoder: RTL and testbench

Rate-1/2, constraint-length-3 (4-state) convolutional encoder that produces the coded symbol stream the Viterbi decoder (branch metric, ACS, path memory) consumes. It accepts one information bit per handshake and emits one 2-bit symbol per handshake. Each frame is terminated with K-1 zero tail bits, so the trellis ends in state 0; the decoder relies on this for its traceback start state. It sits at the transmit/test-generator end of the decoder datapath.

---
 rtl/conv_encoder.sv | 122 ++++++++++++
 tb/tb_conv_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with a one-deep output register and
// optional two-bit zero tail so every frame ends the trellis in state 00.
module conv_encoder #(
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101,
  parameter bit         TERMINATE = 1'b1,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sreg_q, sreg_d;
  logic               tail_q, tail_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_sym_q, out_sym_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               slot_free;
  logic               accept;
  logic               tail_fire;
  logic               enc_bit;
  logic [2:0]         w;
  logic [1:0]         sym;
  logic [CNT_W-1:0]   cnt_inc;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && (state_q != TAIL) && !reset;
  assign accept    = in_valid && in_ready;
  assign tail_fire = (state_q == TAIL) && slot_free;

  // Tail steps shift in zeros; only accepted data bits enter the register.
  assign enc_bit = accept ? in_bit : 1'b0;
  assign w       = {enc_bit, sreg_q};
  assign sym     = {^(w & G0), ^(w & G1)};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    tail_d      = tail_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    if (out_valid_q && out_ready) begin
      out_last_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_sym_d   = sym;
      out_last_d  = 1'b0;
      sreg_d      = {in_bit, sreg_q[1]};
      cnt_d       = (state_q == IDLE) ? CNT_W'(1) : cnt_inc;
      if (!in_last) begin
        state_d = DATA;
      end else if (TERMINATE) begin
        state_d = TAIL;
        tail_d  = 1'b0;
      end else begin
        // Unterminated frames clear the trellis state for the next frame.
        state_d    = IDLE;
        out_last_d = 1'b1;
        sreg_d     = 2'b00;
      end
    end else if (tail_fire) begin
      out_valid_d = 1'b1;
      out_sym_d   = sym;
      out_last_d  = tail_q;
      cnt_d       = cnt_inc;
      sreg_d      = {1'b0, sreg_q[1]};
      tail_d      = 1'b1;
      if (tail_q) begin
        state_d = IDLE;
        tail_d  = 1'b0;
        sreg_d  = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= 2'b00;
      tail_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE) || out_valid_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: a terminated instance and an unterminated
// instance share clock, reset and out_ready; sel picks which one is driven.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        drvValid = 1'b0;
  logic        drvBit = 1'b0;
  logic        drvLast = 1'b0;
  logic        outReady = 1'b1;
  logic [3:0]  readyPat = 4'b1111;
  int          cyc = 0;

  logic        inReadyA, outValidA, outLastA, busyA;
  logic [1:0]  outSymA;
  logic [15:0] cntA;
  logic        inReadyB, outValidB, outLastB, busyB;
  logic [1:0]  outSymB;
  logic [15:0] cntB;

  logic        monInReady, monValid, monLast, monBusy;
  logic [1:0]  monSym;
  logic [15:0] monCount;

  int          vecCount = 0;
  int          errCount = 0;

  logic [1:0]  symQ[$];
  logic        lastQ[$];
  int          cycQ[$];

  typedef struct {
    logic [7:0]  bits;
    int          nBits;
    logic [15:0] syms;
    int          nSyms;
  } vec_t;

  vec_t vecs[5];

  conv_encoder #(.TERMINATE(1'b1)) dutA (
    .clk(clk), .reset(reset),
    .in_valid(drvValid && !sel), .in_ready(inReadyA),
    .in_bit(drvBit), .in_last(drvLast),
    .out_valid(outValidA), .out_ready(outReady),
    .out_sym(outSymA), .out_last(outLastA),
    .busy(busyA), .sym_count(cntA)
  );

  conv_encoder #(.TERMINATE(1'b0)) dutB (
    .clk(clk), .reset(reset),
    .in_valid(drvValid && sel), .in_ready(inReadyB),
    .in_bit(drvBit), .in_last(drvLast),
    .out_valid(outValidB), .out_ready(outReady),
    .out_sym(outSymB), .out_last(outLastB),
    .busy(busyB), .sym_count(cntB)
  );

  assign monInReady = sel ? inReadyB  : inReadyA;
  assign monValid   = sel ? outValidB : outValidA;
  assign monSym     = sel ? outSymB   : outSymA;
  assign monLast    = sel ? outLastB  : outLastA;
  assign monBusy    = sel ? busyB     : busyA;
  assign monCount   = sel ? cntB      : cntA;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) outReady = readyPat[cyc % 4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Capture every handshake; while stalled the symbol must hold and in_ready stay low.
  logic       stallPrev = 1'b0;
  logic [1:0] heldSym = 2'b00;
  logic       heldLast = 1'b0;
  always @(negedge clk) begin
    #2;
    if (stallPrev && !reset) begin
      checkOutput("hold_valid", monValid, 1'b1);
      checkOutput("hold_sym", monSym, heldSym);
      checkOutput("hold_last", monLast, heldLast);
    end
    if (monValid && !outReady && !reset) begin
      checkOutput("stall_in_ready", monInReady, 1'b0);
    end
    if (monValid && outReady) begin
      symQ.push_back(monSym);
      lastQ.push_back(monLast);
      cycQ.push_back(cyc);
    end
    if (monValid === 1'b0 && monLast !== 1'b0) begin
      checkOutput("last_without_valid", monLast, 1'b0);
    end
    stallPrev = monValid && !outReady && !reset;
    heldSym   = monSym;
    heldLast  = monLast;
  end

  task automatic applyStimulus(input logic b, input logic l, output int waits, output int acc);
    @(negedge clk);
    drvValid = 1'b1;
    drvBit   = b;
    drvLast  = l;
    #1;
    waits = 0;
    while (!monInReady && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) checkOutput("accept_timeout", waits, 0);
    acc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic waitIdle();
    int k;
    @(negedge clk);
    drvValid = 1'b0;
    drvLast  = 1'b0;
    #2;
    k = 0;
    while (monBusy && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (k >= 100) checkOutput("idle_timeout", k, 0);
  endtask

  task automatic runFrame(input logic [7:0] bits, input int n, output int firstAcc);
    int waits, acc;
    symQ.delete(); lastQ.delete(); cycQ.delete();
    firstAcc = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(bits[i], i == n - 1, waits, acc);
      if (i == 0) firstAcc = acc;
    end
    waitIdle();
  endtask

  task automatic checkFrame(input logic [15:0] syms, input int nSyms, input logic [7:0] lastMask,
                            input int firstAcc, input bit timing, input int expCount);
    checkOutput("sym_total", symQ.size(), nSyms);
    for (int j = 0; j < nSyms; j++) begin
      if (j < symQ.size()) begin
        checkOutput($sformatf("sym%0d", j), symQ[j], syms[2*j +: 2]);
        checkOutput($sformatf("last%0d", j), lastQ[j], lastMask[j]);
        if (timing) checkOutput($sformatf("cycle%0d", j), cycQ[j], firstAcc + j);
      end
    end
    checkOutput("sym_count", monCount, expCount);
    checkOutput("busy_after", monBusy, 1'b0);
  endtask

  initial begin
    int firstAcc, acc1, acc2, waits1, waits2;
    logic [7:0] lm;

    vecs[0] = '{bits: 8'b0000_1101, nBits: 4, syms: 16'b0000_1101_0100_1011, nSyms: 6};
    vecs[1] = '{bits: 8'b0000_0001, nBits: 1, syms: 16'b0000_0000_0011_1011, nSyms: 3};
    vecs[2] = '{bits: 8'b0000_0000, nBits: 1, syms: 16'b0000_0000_0000_0000, nSyms: 3};
    vecs[3] = '{bits: 8'b0000_0111, nBits: 3, syms: 16'b0000_0011_0110_0111, nSyms: 5};
    vecs[4] = '{bits: 8'b0000_0010, nBits: 2, syms: 16'b0000_0000_1110_1100, nSyms: 4};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    checkOutput("rst_in_ready", inReadyA, 1'b0);
    checkOutput("rst_out_valid", outValidA, 1'b0);
    checkOutput("rst_out_sym", outSymA, 2'b00);
    checkOutput("rst_out_last", outLastA, 1'b0);
    checkOutput("rst_sym_count", cntA, 0);
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_b_out_valid", outValidB, 1'b0);
    reset = 1'b0;

    // Terminated frames at full throughput.
    for (int v = 0; v < 5; v++) begin
      runFrame(vecs[v].bits, vecs[v].nBits, firstAcc);
      lm = 8'h00;
      lm[vecs[v].nSyms - 1] = 1'b1;
      checkFrame(vecs[v].syms, vecs[v].nSyms, lm, firstAcc, 1'b1, vecs[v].nSyms);
    end

    // Backpressure 1,0,0,1 must not change the symbol stream.
    readyPat = 4'b1001;
    runFrame(vecs[0].bits, vecs[0].nBits, firstAcc);
    checkFrame(vecs[0].syms, vecs[0].nSyms, 8'b0010_0000, firstAcc, 1'b0, 6);
    readyPat = 4'b1111;

    // Reset in the middle of frame 1,1,1,1.
    symQ.delete(); lastQ.delete(); cycQ.delete();
    applyStimulus(1'b1, 1'b0, waits1, acc1);
    applyStimulus(1'b1, 1'b0, waits1, acc1);
    @(negedge clk);
    drvValid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("midrst_in_ready", inReadyA, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    checkOutput("midrst_out_valid", outValidA, 1'b0);
    checkOutput("midrst_sym_count", cntA, 0);
    checkOutput("midrst_busy", busyA, 1'b0);
    checkOutput("midrst_sym_total", symQ.size(), 2);
    if (symQ.size() == 2) begin
      checkOutput("midrst_sym0", symQ[0], 2'b11);
      checkOutput("midrst_sym1", symQ[1], 2'b01);
    end
    reset = 1'b0;
    runFrame(8'b1, 1, firstAcc);
    checkFrame(16'b0011_1011, 3, 8'b0000_0100, firstAcc, 1'b1, 3);

    // Back-to-back frames with in_valid held through the tail.
    symQ.delete(); lastQ.delete(); cycQ.delete();
    applyStimulus(1'b1, 1'b1, waits1, acc1);
    applyStimulus(1'b0, 1'b1, waits2, acc2);
    waitIdle();
    checkOutput("b2b_tail_waits", waits2, 2);
    checkOutput("b2b_accept_cycle", acc2, acc1 + 3);
    checkFrame(16'b0000_0000_0011_1011, 6, 8'b0010_0100, acc1, 1'b1, 3);

    // Unterminated instance: frame 1,1,0 then frame 1.
    sel = 1'b1;
    runFrame(8'b0000_0011, 3, firstAcc);
    checkFrame(16'b0001_0111, 3, 8'b0000_0100, firstAcc, 1'b1, 3);
    runFrame(8'b0000_0001, 1, firstAcc);
    checkFrame(16'b0000_0011, 1, 8'b0000_0001, firstAcc, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
